// File: rtl/dmem_pkg.sv
// Shared definitions for the pixel data-memory responder: FSM state encoding,
// default geometry and pixel width.
package dmem_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DEPTH_DEF  = 4096;
  localparam int PIX_W      = 8;
  localparam int BUS_W      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bundle between the memory address register side (master)
// and the data-memory responder (slave).
interface dmem_resp_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W_DEF
);

  logic [ADDR_W-1:0]          dm_addr;
  logic                       dm_wr;
  logic                       dm_r;
  logic [dmem_pkg::BUS_W-1:0] wr_data;
  logic [dmem_pkg::BUS_W-1:0] rd_data;
  logic                       busy;
  logic                       done;
  logic                       addr_err;

  modport master (
    output dm_addr, dm_wr, dm_r, wr_data,
    input  rd_data, busy, done, addr_err
  );

  modport slave (
    input  dm_addr, dm_wr, dm_r, wr_data,
    output rd_data, busy, done, addr_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port pixel store: DEPTH x 8, one write enable, registered read that
// only updates when a read is requested.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  // Power-up contents are all zero; reset deliberately never touches them.
  logic [PIX_W-1:0] mem_reg [DEPTH] = '{default: '0};
  logic [PIX_W-1:0] rdata_reg;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one request at a time, performs it in a fixed
// three-cycle IDLE/ACCESS/RESP sequence and reports completion with done.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic        clock,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  state_e state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic              wr_reg;
  logic [PIX_W-1:0]  wdata_reg;
  logic              err_reg;

  logic              done_reg;
  logic              addr_err_reg;
  logic [BUS_W-1:0]  rd_data_reg;

  logic              req;
  logic              accept;
  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [PIX_W-1:0]  ram_q;
  logic [BUS_W-1:0]  resp_data;
  logic              resp_read;
  logic              unused_bits;

  assign req      = bus.dm_wr | bus.dm_r;
  assign accept   = (state_reg == IDLE) && req;
  // Full-width compare: addresses past DEPTH never alias back into the array.
  assign in_range = ({1'b0, bus.dm_addr} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      addr_err_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= (state_reg == ACCESS);
      addr_err_reg <= (state_reg == ACCESS) && err_reg;
      if (resp_read) begin
        rd_data_reg <= resp_data;
      end
    end
  end

  // Request latches; everything after acceptance works only from these.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_reg  <= bus.dm_addr;
      wr_reg    <= bus.dm_wr;
      wdata_reg <= bus.wr_data[PIX_W-1:0];
      err_reg   <= !in_range;
    end
  end

  // Write is gated by rst so a reset landing in ACCESS leaves memory intact.
  assign ram_we = rst && (state_reg == ACCESS) && wr_reg && !err_reg;
  assign ram_re = (state_reg == ACCESS) && !wr_reg && !err_reg;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_reg[AW-1:0]),
    .wdata (wdata_reg),
    .rdata (ram_q)
  );

  assign resp_read = (state_reg == RESP) && !wr_reg;
  assign resp_data = err_reg ? '0 : {{(BUS_W - PIX_W){1'b0}}, ram_q};

  // Fresh read data is visible in RESP alongside done, then held in rd_data_reg.
  assign bus.rd_data  = resp_read ? resp_data : rd_data_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.addr_err = addr_err_reg;

  assign unused_bits = ^{bus.wr_data[BUS_W-1:PIX_W], addr_reg[ADDR_W-1:AW]};

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model.
module tb_dmem_resp;

  localparam int DEPTH = 4096;

  logic clock;
  logic rst;

  dmem_resp_if #(.ADDR_W(20)) bus ();

  dmem_resp #(
    .ADDR_W (20),
    .DEPTH  (DEPTH)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference model: memory image plus "cycles until idle" for the request in flight.
  byte unsigned mem_m [DEPTH];
  int           remain = 0;
  logic         p_wr;
  logic [19:0]  p_addr;
  logic [7:0]   p_data;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic         exp_err  = 1'b0;
  logic [31:0]  exp_rd   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic w, input logic r, input logic rn,
                            input logic [19:0] a, input logic [31:0] d);
    if (!rn) begin
      remain   = 0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_rd   = '0;
    end else if (remain == 0) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (w || r) begin
        remain = 2;
        p_wr   = w;
        p_addr = a;
        p_data = d[7:0];
      end
    end else if (remain == 2) begin
      remain   = 1;
      exp_done = 1'b1;
      exp_err  = (int'(p_addr) >= DEPTH);
      if (p_wr) begin
        if (!exp_err) mem_m[p_addr[11:0]] = p_data;
      end else begin
        exp_rd = exp_err ? 32'd0 : {24'd0, mem_m[p_addr[11:0]]};
      end
    end else begin
      remain   = 0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
    end
    exp_busy = (remain != 0);
  endtask

  task automatic step(input logic w, input logic r, input logic rn,
                      input logic [19:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.dm_wr   = w;
    bus.dm_r    = r;
    bus.dm_addr = a;
    bus.wr_data = d;
    rst         = rn;
    @(posedge clock);
    model_edge(w, r, rn, a, d);
    #1;
  endtask

  // One request, with conflicting traffic driven while busy; returns outputs seen with done.
  task automatic txn(input logic w, input logic r, input logic [19:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    step(w, r, 1'b1, a, d);
    chk("accept_busy", {31'd0, bus.busy}, 32'd1);
    step(1'b1, 1'b1, 1'b1, a ^ 20'h00005, 32'hFFFF_FFFF);
    chk("done_hi", {31'd0, bus.done}, 32'd1);
    rd  = bus.rd_data;
    err = bus.addr_err;
    step(1'b1, 1'b0, 1'b1, a ^ 20'h00003, 32'hFFFF_FF99);
    chk("done_lo", {31'd0, bus.done}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    $display("txn wr=%0b rd=%0b addr=%05h wdata=%08h -> rd_data=%08h addr_err=%0b",
             w, r, a, d, rd, err);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy",     {31'd0, bus.busy},     {31'd0, exp_busy});
      chk("done",     {31'd0, bus.done},     {31'd0, exp_done});
      chk("addr_err", {31'd0, bus.addr_err}, {31'd0, exp_err});
      chk("rd_data",  bus.rd_data,           exp_rd);
    end
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [5:0]  done_mask;
    logic [19:0] hold_addr [6];
    logic [19:0] a;
    int          sel;

    rst         = 1'b0;
    bus.dm_wr   = 1'b0;
    bus.dm_r    = 1'b0;
    bus.dm_addr = '0;
    bus.wr_data = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'd0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 20'd0, 32'd0);
    chk_en = 1'b1;
    chk("rst_busy",  {31'd0, bus.busy},     32'd0);
    chk("rst_done",  {31'd0, bus.done},     32'd0);
    chk("rst_err",   {31'd0, bus.addr_err}, 32'd0);
    chk("rst_rd",    bus.rd_data,           32'd0);

    // Write then read back
    txn(1'b1, 1'b0, 20'h00010, 32'hDEADBEA5, rd, err);
    chk("wr_keeps_rd", rd, 32'd0);
    txn(1'b0, 1'b1, 20'h00010, 32'd0, rd, err);
    chk("rd_a5", rd, 32'h0000_00A5);
    chk("rd_a5_err", {31'd0, err}, 32'd0);

    // Simultaneous write and read is a write
    txn(1'b1, 1'b1, 20'h00005, 32'h0000_003C, rd, err);
    chk("conflict_rd_held", rd, 32'h0000_00A5);
    txn(1'b0, 1'b1, 20'h00005, 32'd0, rd, err);
    chk("conflict_rd5", rd, 32'h0000_003C);

    // Out of range, no aliasing
    txn(1'b1, 1'b0, 20'd4095, 32'h0000_0011, rd, err);
    chk("w4095_err", {31'd0, err}, 32'd0);
    txn(1'b1, 1'b0, 20'd4096, 32'h0000_0077, rd, err);
    chk("w4096_err", {31'd0, err}, 32'd1);
    chk("w4096_rd", rd, 32'h0000_003C);
    txn(1'b0, 1'b1, 20'd4096, 32'd0, rd, err);
    chk("r4096_err", {31'd0, err}, 32'd1);
    chk("r4096_rd", rd, 32'd0);
    txn(1'b0, 1'b1, 20'd4095, 32'd0, rd, err);
    chk("r4095_rd", rd, 32'h0000_0011);
    txn(1'b0, 1'b1, 20'd0, 32'd0, rd, err);
    chk("r0_no_alias", rd, 32'd0);

    // dm_r held for 6 cycles, address moving while busy
    hold_addr = '{20'h00010, 20'h00005, 20'h00005, 20'h00005, 20'h00010, 20'h00010};
    done_mask = '0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b1, hold_addr[k], 32'd0);
      done_mask[k] = bus.done;
      if (k == 1) chk("hold_rd1", bus.rd_data, 32'h0000_00A5);
      if (k == 4) chk("hold_rd2", bus.rd_data, 32'h0000_003C);
    end
    chk("hold_done_mask", {26'd0, done_mask}, 32'b010010);
    step(1'b0, 1'b0, 1'b1, 20'd0, 32'd0);
    chk("hold_idle", {31'd0, bus.busy}, 32'd0);

    // Reset during ACCESS of a write
    txn(1'b1, 1'b0, 20'd7, 32'h0000_0021, rd, err);
    step(1'b1, 1'b0, 1'b1, 20'd7, 32'h0000_0055);
    step(1'b0, 1'b0, 1'b0, 20'd7, 32'h0000_0055);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 20'd0, 32'd0);
    chk("abort_no_done", {31'd0, bus.done}, 32'd0);
    txn(1'b0, 1'b1, 20'd7, 32'd0, rd, err);
    chk("abort_mem_kept", rd, 32'h0000_0021);

    // Reset while idle after a read
    txn(1'b0, 1'b1, 20'd5, 32'd0, rd, err);
    chk("pre_rst_rd", rd, 32'h0000_003C);
    step(1'b0, 1'b0, 1'b0, 20'd0, 32'd0);
    chk("idle_rst_rd",   bus.rd_data,           32'd0);
    chk("idle_rst_busy", {31'd0, bus.busy},     32'd0);
    chk("idle_rst_done", {31'd0, bus.done},     32'd0);
    chk("idle_rst_err",  {31'd0, bus.addr_err}, 32'd0);
    txn(1'b0, 1'b1, 20'd5, 32'd0, rd, err);
    chk("post_rst_rd", rd, 32'h0000_003C);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 20'($urandom_range(0, 15));
      else if (sel < 9) a = 20'($urandom_range(4090, 4100));
      else              a = 20'($urandom);
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 49) != 0), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
